mux_4to1_arbiter: RTL

Round-robin arbiter and sequencer that shares one 4:1 nibble mux datapath between four requesters. It grants a single requester, steers the mux select, and forwards that requester's 4-bit words to one downstream consumer over a valid/ready handshake. A grant lasts a bounded burst, then rotates. It sits between the request sources and the shared consumer and owns the mux select.

---
 rtl/mux_4to1_arbiter_pkg.sv | 15 +
 rtl/mux_4to1_arbiter_rr_pick4.sv | 30 +++
 rtl/mux_4to1_arbiter.sv | 103 ++++++++++
 3 files changed

// File: rtl/mux_4to1_arbiter_pkg.sv
// Shared definitions for the 4-requester round-robin mux arbiter.
// FSM encodings, requester count and select width, plus a one-hot helper.
package mux_4to1_arbiter_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux_4to1_arbiter_rr_pick4.sv
// Round-robin picker: first set request scanning upward from last+1 with wrap.
// Purely combinational, zero latency; no flow control of its own.
module rr_pick4
    import mux_4to1_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               any,
    output logic [SEL_W-1:0]   winner
);

    logic [SEL_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        any     = |req;
        winner  = last;
        w_found = 1'b0;
        w_idx   = last;
        // offset 4 wraps back onto last itself, so it only wins when alone
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = last + 2'(k);
            if (!w_found && req[w_idx]) begin
                winner  = w_idx;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_4to1_arbiter.sv
// Round-robin grant of one of four requesters onto a shared nibble stream; 1-cycle arbitration, bounded bursts.
// out_ready low freezes grant, sel and beat count; req_ready follows out_ready only for the granted requester.
module mux_4to1_arbiter
    import mux_4to1_arbiter_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          sel,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy
);

    localparam logic [3:0] LP_LAST_BEAT = 4'(MAX_BURST - 1);

    logic               r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_last;
    logic [NUM_REQ-1:0] r_grant;
    logic [3:0]         r_beat_cnt;

    logic               w_any;
    logic [SEL_W-1:0]   w_winner;
    logic               w_busy;
    logic               w_sel_valid;
    logic               w_beat;
    logic [DATA_W-1:0]  w_words [NUM_REQ];

    rr_pick4 u_pick (
        .req    (req_valid),
        .last   (r_last),
        .any    (w_any),
        .winner (w_winner)
    );

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_words[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    assign w_busy      = (r_state == ST_GRANT);
    assign w_sel_valid = req_valid[r_sel];
    assign w_beat      = w_busy && w_sel_valid && out_ready;

    always_comb begin
        req_ready = '0;
        if (w_busy) begin
            req_ready[r_sel] = out_ready;
        end
    end

    assign out_valid = w_busy && w_sel_valid;
    assign out_data  = w_words[r_sel];
    assign sel       = r_sel;
    assign grant     = r_grant;
    assign busy      = w_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_last     <= 2'd3;
            r_grant    <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state    <= ST_GRANT;
                        r_sel      <= w_winner;
                        r_last     <= w_winner;
                        r_grant    <= onehot4(w_winner);
                        r_beat_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    // an empty granted requester gives up its slot at once
                    if (!w_sel_valid || (w_beat && r_beat_cnt == LP_LAST_BEAT)) begin
                        r_state    <= ST_IDLE;
                        r_grant    <= '0;
                        r_beat_cnt <= '0;
                    end else if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule
